// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the write-side FIFO arbiter.
//   DATA_W        : FIFO word width
//   data_t        : one FIFO write word
//   arb_state_t   : arbiter FSM states
//   NUM_REQ_DEF   : default number of producers
//   MAX_BURST_DEF : default transfers per grant before re-arbitration
package fifo_wr_arbiter_pkg;

  localparam int unsigned DATA_W        = 16;
  localparam int unsigned NUM_REQ_DEF   = 4;
  localparam int unsigned MAX_BURST_DEF = 8;
  localparam int unsigned BURST_W       = 8;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set bit of i_req at or above i_ptr, wrapping to
// the lowest set bit when nothing at or above i_ptr is requesting.
//   i_req : request vector
//   i_ptr : round-robin start position
//   o_any : at least one request is set
//   o_idx : index of the selected requester (valid when o_any)
module fifo_wr_arbiter_rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic                       o_any,
  output logic [$clog2(NUM_REQ)-1:0] o_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_masked;
  logic [NUM_REQ-1:0] w_vec;
  logic               w_found;

  // Mask off requesters below the pointer; fall back to the full vector on wrap.
  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_mask[i] = (IDX_W'(i) >= i_ptr);
    end
    w_masked = i_req & w_mask;
    w_vec    = (|w_masked) ? w_masked : i_req;
  end

  // Lowest-index priority encoder over the selected vector.
  always_comb begin
    o_idx   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_vec[i] && !w_found) begin
        o_idx   = IDX_W'(i);
        w_found = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the FIFO write port among NUM_REQ producers with round-robin grants
// and a bounded burst per grant; FIFO full back-pressures the owner.
//   wr_clk, wr_rst : write clock, synchronous active-high reset
//   req, req_data  : per-producer valid and data
//   ready          : word of requester i taken when req[i] & ready[i]
//   push, data_out : FIFO write strobe and data (data_out is 0 when push is 0)
//   full           : FIFO full, gates push in the same cycle
//   owner, busy    : current grant holder and grant-held flag
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic                       wr_clk,
  input  logic                       wr_rst,
  input  logic [NUM_REQ-1:0]         req,
  input  data_t [NUM_REQ-1:0]        req_data,
  output logic [NUM_REQ-1:0]         ready,
  output logic                       push,
  output data_t                      data_out,
  input  logic                       full,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy
);

  localparam int unsigned          IDX_W      = $clog2(NUM_REQ);
  localparam logic [BURST_W-1:0]   BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(NUM_REQ - 1);

  arb_state_t         r_state;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [BURST_W-1:0] r_burst_cnt;

  logic               w_any;
  logic [IDX_W-1:0]   w_pick;
  logic               w_owner_req;
  logic               w_xfer;
  logic               w_last;
  logic [IDX_W-1:0]   w_next_ptr;

  fifo_wr_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req (req),
    .i_ptr (r_rr_ptr),
    .o_any (w_any),
    .o_idx (w_pick)
  );

  // A transfer happens only while granted, the owner is valid and the FIFO has room.
  assign w_owner_req = req[r_owner];
  assign w_xfer      = (r_state == ARB_GRANT) && w_owner_req && !full;
  assign w_last      = w_xfer && (r_burst_cnt == BURST_LAST);
  assign w_next_ptr  = (r_owner == IDX_LAST) ? '0 : r_owner + IDX_W'(1);

  // Grant FSM: IDLE picks the next owner, GRANT streams until release or burst limit.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      r_state     <= ARB_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          r_burst_cnt <= '0;
          if (w_any) begin
            r_owner <= w_pick;
            r_state <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (w_xfer) begin
            r_burst_cnt <= r_burst_cnt + BURST_W'(1);
          end
          // A stalled (full) owner keeps its grant as long as it still requests.
          if (!w_owner_req || w_last) begin
            r_state  <= ARB_IDLE;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  // Write-port mux; push and ready follow full in the same cycle so the FIFO never overflows.
  assign push     = w_xfer;
  assign ready    = w_xfer ? (NUM_REQ'(1) << r_owner) : '0;
  assign data_out = w_xfer ? req_data[r_owner] : '0;
  assign owner    = r_owner;
  assign busy     = (r_state == ARB_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, single producer bursts, fairness,
// back-pressure, early release, reset mid-burst and a randomised scoreboard run.
module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        req;
  data_t [3:0]       req_data;
  logic              full;

  logic [3:0]        ready, ready2;
  logic              push, push2;
  data_t             data_out, data_out2;
  logic [1:0]        owner, owner2;
  logic              busy, busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(4), .MAX_BURST(8)) dut (
    .wr_clk(clk), .wr_rst(rst), .req(req), .req_data(req_data), .ready(ready),
    .push(push), .data_out(data_out), .full(full), .owner(owner), .busy(busy)
  );

  fifo_wr_arbiter #(.NUM_REQ(4), .MAX_BURST(2)) dut2 (
    .wr_clk(clk), .wr_rst(rst), .req(req), .req_data(req_data), .ready(ready2),
    .push(push2), .data_out(data_out2), .full(full), .owner(owner2), .busy(busy2)
  );

  // Advance to 1 time unit past the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; full = 1'b0; req_data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; full = 1'b0; req_data = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      checks++;
      if (ready !== 4'b0 || push !== 1'b0 || busy !== 1'b0 || owner !== 2'd0) begin
        errors++;
        $display("FAIL reset cyc%0d: ready=%b push=%b busy=%b owner=%0d, required all 0",
                 c, ready, push, busy, owner);
      end
    end
    rst = 1'b0; req = '0;
  endtask

  task automatic test_single();
    int sent;
    logic exp_push;
    do_reset();
    sent = 0;
    tick();
    req = 4'b0100; req_data[2] = 16'h2000;
    #1;
    checks++;
    if (push !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: push=%b busy=%b, required 0 0", push, busy);
    end
    for (int c = 0; c < 22; c++) begin
      tick();
      req_data[2] = 16'h2000 + 16'(sent);
      #1;
      exp_push = (c != 8) && (c != 17);
      checks++;
      if (push !== exp_push) begin
        errors++;
        $display("FAIL single_push c%0d: push=%b, required %b", c, push, exp_push);
      end
      if (push === 1'b1) begin
        checks++;
        if (data_out !== 16'h2000 + 16'(sent) || owner !== 2'd2 || ready !== 4'b0100) begin
          errors++;
          $display("FAIL single_word %0d: data=%h owner=%0d ready=%b, required %h 2 0100",
                   sent, data_out, owner, ready, 16'h2000 + 16'(sent));
        end
        sent++;
      end else begin
        checks++;
        if (data_out !== '0 || ready !== 4'b0) begin
          errors++;
          $display("FAIL single_bubble c%0d: data=%h ready=%b, required 0 0", c, data_out, ready);
        end
      end
    end
    checks++;
    if (sent != 20) begin
      errors++;
      $display("FAIL single_count: words=%0d, required 20", sent);
    end
    req = '0;
  endtask

  task automatic test_fairness();
    int exp_own, in_turn, pushes, cyc;
    int cnt [4];
    logic [3:0] exp_rdy;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_data[i] = data_t'(i << 12);
      cnt[i] = 0;
    end
    tick();
    req = 4'b1111;
    #1;
    checks++;
    if (push2 !== 1'b0) begin
      errors++;
      $display("FAIL fair_latency: push=%b, required 0", push2);
    end
    exp_own = 0; in_turn = 0; pushes = 0; cyc = 0;
    while (pushes < 64 && cyc < 200) begin
      tick();
      #1;
      cyc++;
      checks++;
      if (push2 === 1'b1) begin
        exp_rdy = 4'b0001 << exp_own;
        if (owner2 !== 2'(exp_own) || data_out2 !== req_data[exp_own] || ready2 !== exp_rdy) begin
          errors++;
          $display("FAIL fair_order push%0d: owner=%0d data=%h ready=%b, required owner %0d",
                   pushes, owner2, data_out2, ready2, exp_own);
        end
        cnt[owner2]++;
        pushes++;
        in_turn++;
        if (in_turn == 2) begin
          in_turn = 0;
          exp_own = (exp_own + 1) % 4;
        end
      end else if (in_turn != 0 || busy2 !== 1'b0) begin
        errors++;
        $display("FAIL fair_bubble cyc%0d: pushes_in_turn=%0d busy=%b, required 0 0",
                 cyc, in_turn, busy2);
      end
    end
    checks++;
    if (cyc != 95) begin
      errors++;
      $display("FAIL fair_cycles: last push at cycle %0d, required 95", cyc);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cnt[i] < 14 || cnt[i] > 18) begin
        errors++;
        $display("FAIL fair_count req%0d: words=%0d, required 16+-2", i, cnt[i]);
      end
    end
    req = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_data[1] = 16'h1234;
    tick();
    req = 4'b0010;
    #1;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      checks++;
      if (push !== 1'b1 || owner !== 2'd1 || data_out !== 16'h1234) begin
        errors++;
        $display("FAIL bp_pre c%0d: push=%b owner=%0d data=%h, required 1 1 1234",
                 c, push, owner, data_out);
      end
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      full = 1'b1;
      #1;
      checks++;
      if (push !== 1'b0 || ready !== 4'b0 || owner !== 2'd1 || busy !== 1'b1 ||
          dut.r_burst_cnt !== 8'd3) begin
        errors++;
        $display("FAIL bp_full c%0d: push=%b ready=%b owner=%0d busy=%b burst=%0d, required 0 0 1 1 3",
                 c, push, ready, owner, busy, dut.r_burst_cnt);
      end
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      full = 1'b0;
      #1;
      checks++;
      if (c < 5) begin
        if (push !== 1'b1 || ready !== 4'b0010) begin
          errors++;
          $display("FAIL bp_resume c%0d: push=%b ready=%b, required 1 0010", c, push, ready);
        end
      end else if (push !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL bp_rearb: push=%b busy=%b, required 0 0", push, busy);
      end
    end
    req = '0;
  endtask

  task automatic test_early_release();
    do_reset();
    req_data[0] = 16'h0abc; req_data[3] = 16'h3def;
    tick();
    req = 4'b1001;
    #1;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      checks++;
      if (push !== 1'b1 || owner !== 2'd0 || data_out !== 16'h0abc || ready !== 4'b0001) begin
        errors++;
        $display("FAIL early_burst c%0d: push=%b owner=%0d data=%h ready=%b, required 1 0 0abc 0001",
                 c, push, owner, data_out, ready);
      end
    end
    tick();
    req = 4'b1000;
    #1;
    checks++;
    if (push !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL early_drop: push=%b busy=%b, required 0 1", push, busy);
    end
    tick();
    #1;
    checks++;
    if (push !== 1'b0 || busy !== 1'b0 || dut.r_rr_ptr !== 2'd1) begin
      errors++;
      $display("FAIL early_idle: push=%b busy=%b rr_ptr=%0d, required 0 0 1",
               push, busy, dut.r_rr_ptr);
    end
    tick();
    #1;
    checks++;
    if (push !== 1'b1 || owner !== 2'd3 || busy !== 1'b1 || data_out !== 16'h3def) begin
      errors++;
      $display("FAIL early_regrant: push=%b owner=%0d busy=%b data=%h, required 1 3 1 3def",
               push, owner, busy, data_out);
    end
  endtask

  // Continues from test_early_release with owner 3 mid-burst.
  task automatic test_reset_mid_burst();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (push !== 1'b1 || ready !== 4'b1000) begin
      errors++;
      $display("FAIL rst_inflight: push=%b ready=%b, required 1 1000", push, ready);
    end
    tick();
    rst = 1'b0; req = '0;
    #1;
    checks++;
    if (push !== 1'b0 || busy !== 1'b0 || owner !== 2'd0 || dut.r_rr_ptr !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid: push=%b busy=%b owner=%0d rr_ptr=%0d, required 0 0 0 0",
               push, busy, owner, dut.r_rr_ptr);
    end
  endtask

  task automatic test_end_to_end();
    int seq [4];
    int sb_next [4];
    int total;
    int id;
    logic [3:0] exp_rdy;
    do_reset();
    total = 0;
    for (int i = 0; i < 4; i++) begin
      seq[i] = 0;
      sb_next[i] = 0;
    end
    for (int c = 0; c < 600; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (req[i] && $urandom_range(9) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(1) == 0) req[i] = 1'b1;
        req_data[i] = data_t'({4'(i), 12'(seq[i])});
      end
      full = ($urandom_range(3) == 0);
      #1;
      checks++;
      if (push === 1'b1) begin
        id = int'(data_out[15:12]);
        exp_rdy = 4'b0001 << owner;
        if (full !== 1'b0 || id != int'(owner) || req[owner] !== 1'b1 ||
            ready !== exp_rdy || int'(data_out[11:0]) != sb_next[id]) begin
          errors++;
          $display("FAIL e2e c%0d: data=%h owner=%0d ready=%b full=%b, required seq %0d from owner",
                   c, data_out, owner, ready, full, (id < 4) ? sb_next[id] : -1);
        end
        if (id < 4) sb_next[id]++;
        total++;
      end else if (ready !== 4'b0 || data_out !== '0) begin
        errors++;
        $display("FAIL e2e_idle c%0d: ready=%b data=%h, required 0 0", c, ready, data_out);
      end
      for (int i = 0; i < 4; i++) begin
        if (req[i] && ready[i]) seq[i]++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sb_next[i] != seq[i] || seq[i] == 0) begin
        errors++;
        $display("FAIL e2e_count req%0d: pushed=%0d, accepted=%0d (nonzero required)",
                 i, sb_next[i], seq[i]);
      end
    end
    req = '0; full = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_early_release();
    test_reset_mid_burst();
    test_end_to_end();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
